bfloat16_result_fifo: RTL
=========================

BFLOAT16_RESULT_FIFO -- requirements
Module: bfloat16_result_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0400: word-aligned wishbone base address; the block decodes 16 bytes from it.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries, a power of two, 2..16.
REQ-003 SHALL have parameter IRQ_THRESH, default 4: occupancy at or above which irq_o asserts.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 wb_clk_i  in  1  system clock, all logic on its rising edge.
REQ-006 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-007 res_valid_i  in  1  FMA result strobe.
REQ-008 res_data_i  in  32  FMA result word.
REQ-009 res_flags_i  in  10  FMA exception flags for that result.
REQ-010 res_ready_o  out  1  high when an entry can be accepted.
REQ-011 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  wishbone cycle, strobe and write enable.
REQ-012 wbs_sel_i  in  4  byte select; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-013 wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-014 irq_o  out  1  level interrupt.

Function
REQ-015 SHALL buffer {res_flags_i, res_data_i} entries (42 bits) in FIFO order and drain them through wishbone reads.
REQ-016 Push: a push occurs on a rising edge with res_valid_i=1 and res_ready_o=1.
REQ-017 res_ready_o SHALL be !full, combinational from registered state.
REQ-018 Overflow: res_valid_i=1 while full with no pop in the same cycle SHALL drop the entry and set sticky OVF.
REQ-019 Full with a pop in the same cycle: the push SHALL be accepted and the count SHALL remain DEPTH.
REQ-020 The block SHALL decode an access when cyc&stb is high, wbs_adr_i[31:4]==BASE_ADDR[31:4], and ack is low.
REQ-021 Access not decoded (address out of range): no ack, no state change.
REQ-022 wbs_ack_o SHALL pulse for one cycle, one cycle after the decode; the next access decodes no earlier than the cycle after the ack.
REQ-023 wbs_dat_o SHALL be valid while ack is high and 0 otherwise.
REQ-024 Offset 0x0 DATA (read): returns head res_data and pops the head in the ack cycle.
REQ-025 Offset 0x0 DATA read when empty: returns 0, does not pop, sets sticky UDF.
REQ-026 Offset 0x4 FLAGS (read): returns {22'b0, head flags}, no pop; returns 0 when empty.
REQ-027 Offset 0x8 STATUS (read): returns {16'b0, count[7:0], 4'b0, UDF, OVF, full, empty}.
REQ-028 Offset 0xC CTRL (write, applied only when wbs_sel_i[0]=1):
  - bit0 flush: empties the FIFO;
  - bit1: clears OVF;
  - bit2: clears UDF.
REQ-029 Writes to offsets 0x0, 0x4 and 0x8 SHALL be acked and ignored; CTRL SHALL read as 0.
REQ-030 Flush and push in the same cycle: flush SHALL win, the entry is discarded, OVF is unchanged.
REQ-031 A same-cycle OVF set and CTRL clear SHALL leave OVF set.
REQ-032 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-033 count SHALL be log2(DEPTH)+1 bits, with full = (count==DEPTH) and empty = (count==0).
REQ-034 irq_o SHALL be registered: (count>=IRQ_THRESH) | OVF, updated the cycle after count or OVF changes.
REQ-035 Push-to-visibility latency: an entry pushed at edge N SHALL be readable by an access decoded at edge N+1 or later.

Reset
REQ-036 While wb_rst_ni=0, independent of the clock, the block SHALL hold:
  - pointers and count at 0;
  - OVF and UDF at 0;
  - wbs_ack_o, wbs_dat_o and irq_o at 0;
  - res_ready_o at 1.
REQ-037 Reset asserted mid-access SHALL abort the access with no ack issued; FIFO contents become don't-care.
REQ-038 The first push SHALL be allowed on the first rising edge after wb_rst_ni rises.

Verification
REQ-039 Push A=0x0000_3F80 (flags 0x001), then B=0x0000_4000 (flags 0x000) -> FLAGS reads 0x001; DATA reads 0x3F80 then 0x4000; STATUS reads 0x0000_0001.
REQ-040 Push 9 entries with DEPTH=8 and no reads -> res_ready_o=0 after the 8th; STATUS=0x0000_0806; irq_o=1; the 9th entry is lost (the 8 reads return only the first 8).
REQ-041 Read DATA when empty -> returns 0 with a single ack; STATUS bit3 (UDF)=1; a CTRL write of 0x4 clears it.
REQ-042 Full FIFO with push and DATA-read pop in the same cycle -> count stays 8, OVF stays 0, FIFO order is preserved across wrap-around.
REQ-043 Push 3 entries, then CTRL write 0x1 coincident with a push -> STATUS=0x0000_0001; irq_o=0.
REQ-044 Assert wb_rst_ni=0 asynchronously while a read is decoded -> no ack; all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/bfloat16_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bfloat16_result_fifo
// Description : Buffers FMA result words plus exception flags and drains
//               them through a small wishbone slave register window
//               (DATA / FLAGS / STATUS / CTRL), with a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module bfloat16_result_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0400,
    parameter int          DEPTH      = 8,
    parameter int          IRQ_THRESH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        res_valid_i,
    input  logic [31:0] res_data_i,
    input  logic [9:0]  res_flags_i,
    output logic        res_ready_o,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(DEPTH);

    logic [41:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic            r_udf;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic            r_irq;

    logic            w_full;
    logic            w_empty;
    logic            w_dec;
    logic [1:0]      w_off;
    logic            w_rd;
    logic            w_ctrl_wr;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_ovf_clr;
    logic            w_udf_set;
    logic            w_udf_clr;
    logic [41:0]     w_head;
    logic [31:0]     w_rd_mux;
    logic            w_unused;

    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_head    = r_mem[r_rptr];

    // An access is taken only while no ack is outstanding, so a held strobe
    // cannot decode twice back to back.
    assign w_dec     = wbs_cyc_i & wbs_stb_i & ~r_ack &
                       (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off     = wbs_adr_i[3:2];
    assign w_rd      = w_dec & ~wbs_we_i;
    assign w_ctrl_wr = w_dec & wbs_we_i & (w_off == 2'd3) & wbs_sel_i[0];
    assign w_flush   = w_ctrl_wr & wbs_dat_i[0];
    assign w_pop     = w_rd & (w_off == 2'd0) & ~w_empty;
    assign w_udf_set = w_rd & (w_off == 2'd0) & w_empty;
    assign w_udf_clr = w_ctrl_wr & wbs_dat_i[2];
    assign w_ovf_clr = w_ctrl_wr & wbs_dat_i[1];

    // A full FIFO still takes a push when the head leaves in the same edge;
    // a flush discards any coincident push without flagging overflow.
    assign w_push    = res_valid_i & (~w_full | w_pop) & ~w_flush;
    assign w_ovf_set = res_valid_i & w_full & ~w_pop & ~w_flush;

    assign res_ready_o = ~w_full;
    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign irq_o       = r_irq;

    assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:3], wbs_sel_i[3:1]};

    // Register read multiplexer, sampled into r_dat at the decode edge.
    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            2'd0: w_rd_mux = w_empty ? 32'h0 : w_head[31:0];
            2'd1: w_rd_mux = w_empty ? 32'h0 : {22'b0, w_head[41:32]};
            2'd2: w_rd_mux = {16'b0, 8'(r_count), 4'b0, r_udf, r_ovf, w_full, w_empty};
            default: w_rd_mux = '0;
        endcase
    end

    // Entry storage; contents need no reset since count guards every read.
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {res_flags_i, res_data_i};
        end
    end

    // Pointers and occupancy count; flush returns the FIFO to empty.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
        end
    end

    // Sticky error flags; a new overflow beats a same-edge clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
            if (w_udf_set)      r_udf <= 1'b1;
            else if (w_udf_clr) r_udf <= 1'b0;
        end
    end

    // Single-cycle ack with read data, plus the registered interrupt level.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_dec;
            r_dat <= w_rd ? w_rd_mux : 32'h0;
            r_irq <= (32'(r_count) >= 32'(IRQ_THRESH)) | r_ovf;
        end
    end

endmodule
`default_nettype wire
